knn_ctrl: RTL



---
 rtl/knn_pkg.sv | 33 +++
 rtl/knn_ins_list.sv | 88 ++++++++
 rtl/knn_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared constants, FSM encoding and helpers for the knn sequencer
package knn_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ID_W_DEF    = 8;
    localparam int NBR_KNN_DEF = 4;
    localparam int N_TRAIN_DEF = 16;

    // Distance value that marks an empty list slot; never inserted.
    localparam logic [DATA_W_DEF-1:0] DIST_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FILL  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Ceiling log2, never below 1 so that counters always have at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/knn_ins_list.sv
// rtl/knn_ins_list.sv - K-deep sorted (distance, id) list with one-cycle parallel insert
module knn_ins_list
    import knn_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = ID_W_DEF,
    parameter int NBR_KNN = NBR_KNN_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_i,
    input  logic                        ins_i,
    input  logic [DATA_W-1:0]           ins_dist_i,
    input  logic [ID_W-1:0]             ins_id_i,
    input  logic [clog2(NBR_KNN)-1:0]   rd_rank_i,
    output logic [DATA_W-1:0]           rd_dist_o,
    output logic [ID_W-1:0]             rd_id_o
);

    logic [DATA_W-1:0] dist_q [NBR_KNN];
    logic [DATA_W-1:0] dist_d [NBR_KNN];
    logic [ID_W-1:0]   id_q   [NBR_KNN];
    logic [ID_W-1:0]   id_d   [NBR_KNN];

    // le[i]: slot i stays in place because it ranks at or before the newcomer.
    // The list is sorted, so le is a thermometer code from slot 0.
    logic [NBR_KNN-1:0] le;
    logic               ins_take;

    // Per-slot comparison against the incoming distance.
    always_comb begin
        for (int i = 0; i < NBR_KNN; i++) begin
            le[i] = (dist_q[i] <= ins_dist_i);
        end
    end

    // Strictly-less test against the last slot; also rejects all-ones distances.
    assign ins_take = ins_i && !le[NBR_KNN-1];

    // Next-state of every slot: clear, keep, take the newcomer, or shift down.
    always_comb begin
        for (int i = 0; i < NBR_KNN; i++) begin
            dist_d[i] = dist_q[i];
            id_d[i]   = id_q[i];
        end
        if (clr_i) begin
            for (int i = 0; i < NBR_KNN; i++) begin
                dist_d[i] = '1;
                id_d[i]   = '0;
            end
        end else if (ins_take) begin
            if (!le[0]) begin
                dist_d[0] = ins_dist_i;
                id_d[0]   = ins_id_i;
            end
            for (int i = 1; i < NBR_KNN; i++) begin
                if (!le[i]) begin
                    if (le[i-1]) begin
                        dist_d[i] = ins_dist_i;
                        id_d[i]   = ins_id_i;
                    end else begin
                        dist_d[i] = dist_q[i-1];
                        id_d[i]   = id_q[i-1];
                    end
                end
            end
        end
    end

    // Slot registers; reset leaves the list empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBR_KNN; i++) begin
                dist_q[i] <= '1;
                id_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NBR_KNN; i++) begin
                dist_q[i] <= dist_d[i];
                id_q[i]   <= id_d[i];
            end
        end
    end

    assign rd_dist_o = dist_q[rd_rank_i];
    assign rd_id_o   = id_q[rd_rank_i];

endmodule

// File: rtl/knn_ctrl.sv
// rtl/knn_ctrl.sv - knn sequencer: per test point clear, fill N_TRAIN distances, drain K ids
module knn_ctrl
    import knn_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = ID_W_DEF,
    parameter int NBR_KNN = NBR_KNN_DEF,
    parameter int N_TRAIN = N_TRAIN_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [7:0]                  n_test,
    output logic                        busy,
    output logic                        done,
    input  logic                        dist_valid,
    output logic                        dist_ready,
    input  logic [DATA_W-1:0]           dist_in,
    input  logic [ID_W-1:0]             dist_id,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [7:0]                  res_test,
    output logic [clog2(NBR_KNN)-1:0]   res_rank,
    output logic [ID_W-1:0]             res_id,
    output logic [DATA_W-1:0]           res_dist
);

    localparam int RANK_W  = clog2(NBR_KNN);
    localparam int TRAIN_W = clog2(N_TRAIN);

    state_t               state_q, state_d;
    logic [7:0]           n_test_q, n_test_d;
    logic [7:0]           test_cnt_q, test_cnt_d;
    logic [TRAIN_W-1:0]   train_cnt_q, train_cnt_d;
    logic [RANK_W-1:0]    rank_cnt_q, rank_cnt_d;

    logic                 list_clr;
    logic                 list_ins;
    logic                 dist_hs;
    logic                 res_hs;
    logic                 in_drain;
    logic [DATA_W-1:0]    rd_dist;
    logic [ID_W-1:0]      rd_id;

    // Handshake strobes are pure state decodes, so ready/valid never see the peer.
    assign dist_ready = (state_q == S_FILL);
    assign in_drain   = (state_q == S_DRAIN);
    assign res_valid  = in_drain;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign dist_hs    = dist_valid && dist_ready;
    assign res_hs     = res_valid && res_ready;

    // Result fields read zero outside DRAIN so idle/reset values are clean.
    assign res_test = in_drain ? test_cnt_q : 8'd0;
    assign res_rank = in_drain ? rank_cnt_q : '0;
    assign res_id   = in_drain ? rd_id      : '0;
    assign res_dist = in_drain ? rd_dist    : '0;

    // Next-state, counter and list-strobe logic.
    always_comb begin
        state_d     = state_q;
        n_test_d    = n_test_q;
        test_cnt_d  = test_cnt_q;
        train_cnt_d = train_cnt_q;
        rank_cnt_d  = rank_cnt_q;
        list_clr    = 1'b0;
        list_ins    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_test_d   = n_test;
                    test_cnt_d = 8'd0;
                    state_d    = (n_test == 8'd0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                list_clr    = 1'b1;
                train_cnt_d = '0;
                state_d     = S_FILL;
            end
            S_FILL: begin
                if (dist_hs) begin
                    list_ins    = 1'b1;
                    train_cnt_d = train_cnt_q + 1'b1;
                    if (train_cnt_q == TRAIN_W'(N_TRAIN - 1)) begin
                        rank_cnt_d = '0;
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (res_hs) begin
                    rank_cnt_d = rank_cnt_q + 1'b1;
                    if (rank_cnt_q == RANK_W'(NBR_KNN - 1)) begin
                        if (test_cnt_q == n_test_q - 8'd1) begin
                            state_d = S_DONE;
                        end else begin
                            test_cnt_d = test_cnt_q + 8'd1;
                            state_d    = S_CLEAR;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            n_test_q    <= 8'd0;
            test_cnt_q  <= 8'd0;
            train_cnt_q <= '0;
            rank_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_test_q    <= n_test_d;
            test_cnt_q  <= test_cnt_d;
            train_cnt_q <= train_cnt_d;
            rank_cnt_q  <= rank_cnt_d;
        end
    end

    knn_ins_list #(
        .DATA_W  (DATA_W),
        .ID_W    (ID_W),
        .NBR_KNN (NBR_KNN)
    ) u_list (
        .clk        (clk),
        .rst_n      (rst),
        .clr_i      (list_clr),
        .ins_i      (list_ins),
        .ins_dist_i (dist_in),
        .ins_id_i   (dist_id),
        .rd_rank_i  (rank_cnt_q),
        .rd_dist_o  (rd_dist),
        .rd_id_o    (rd_id)
    );

endmodule
